// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: two-stage symbol decode plus word-alignment FSM that
// requests deserialiser bitslips until a run of control tokens is seen.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int SLIP_SETTLE   = 8
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       aligned,
    output logic       de_out,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out
);
    localparam int WIN_MAX = (SEARCH_WINDOW > SLIP_SETTLE) ? SEARCH_WINDOW : SLIP_SETTLE;
    localparam int WIN_W   = $clog2(WIN_MAX + 1);
    localparam int TOK_W   = $clog2(LOCK_TOKENS + 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [9:0]       s1_r;
    logic [TOK_W-1:0] tok_cnt_r, tok_nxt_s;
    logic [WIN_W-1:0] win_cnt_r, win_nxt_s;
    logic             slip_nxt_s;
    logic             tok_hit_s;
    logic [1:0]       tok_val_s;
    logic [7:0]       q_s, dec_s;

    // Control-token recognition and video-byte decode of the S1 symbol
    always_comb begin
        tok_hit_s = 1'b1;
        tok_val_s = 2'b00;
        case (s1_r)
            10'b1101010100: tok_val_s = 2'b00;
            10'b0010101011: tok_val_s = 2'b01;
            10'b0101010100: tok_val_s = 2'b10;
            10'b1010101011: tok_val_s = 2'b11;
            default:        tok_hit_s = 1'b0;
        endcase
        q_s      = s1_r[9] ? ~s1_r[7:0] : s1_r[7:0];
        dec_s    = 8'h00;
        dec_s[0] = q_s[0];
        for (int i = 1; i < 8; i++) begin
            if (s1_r[8]) begin
                dec_s[i] = q_s[i] ^ q_s[i-1];
            end else begin
                dec_s[i] = ~(q_s[i] ^ q_s[i-1]);
            end
        end
    end

    // Token run counter, window counter and alignment FSM next state
    always_comb begin
        state_nxt_s = state_r;
        win_nxt_s   = win_cnt_r;
        slip_nxt_s  = 1'b0;
        if (state_r == SLIP_WAIT) begin
            tok_nxt_s = {TOK_W{1'b0}};
        end else if (!tok_hit_s) begin
            tok_nxt_s = {TOK_W{1'b0}};
        end else if (tok_cnt_r == TOK_W'(LOCK_TOKENS)) begin
            tok_nxt_s = tok_cnt_r;
        end else begin
            tok_nxt_s = tok_cnt_r + TOK_W'(1);
        end
        case (state_r)
            SEARCH: begin
                // Lock takes priority over window expiry on the same cycle
                if (tok_nxt_s == TOK_W'(LOCK_TOKENS)) begin
                    state_nxt_s = LOCKED;
                    win_nxt_s   = {WIN_W{1'b0}};
                end else if (win_cnt_r == WIN_W'(SEARCH_WINDOW - 1)) begin
                    state_nxt_s = SLIP_WAIT;
                    win_nxt_s   = {WIN_W{1'b0}};
                    slip_nxt_s  = 1'b1;
                end else begin
                    win_nxt_s   = win_cnt_r + WIN_W'(1);
                end
            end
            SLIP_WAIT: begin
                if (win_cnt_r == WIN_W'(SLIP_SETTLE - 1)) begin
                    state_nxt_s = SEARCH;
                    win_nxt_s   = {WIN_W{1'b0}};
                end else begin
                    win_nxt_s   = win_cnt_r + WIN_W'(1);
                end
            end
            LOCKED: begin
                if (tok_hit_s) begin
                    win_nxt_s   = {WIN_W{1'b0}};
                end else if (win_cnt_r == WIN_W'(SEARCH_WINDOW - 1)) begin
                    state_nxt_s = SEARCH;
                    win_nxt_s   = {WIN_W{1'b0}};
                end else begin
                    win_nxt_s   = win_cnt_r + WIN_W'(1);
                end
            end
            default: begin
                state_nxt_s = SEARCH;
                win_nxt_s   = {WIN_W{1'b0}};
            end
        endcase
    end

    // State, counters, S1/S2 pipeline and registered outputs
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_r   <= SEARCH;
            tok_cnt_r <= {TOK_W{1'b0}};
            win_cnt_r <= {WIN_W{1'b0}};
            s1_r      <= 10'd0;
            bitslip   <= 1'b0;
            aligned   <= 1'b0;
            de_out    <= 1'b0;
            data_out  <= 8'h00;
            ctrl_out  <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            tok_cnt_r <= tok_nxt_s;
            win_cnt_r <= win_nxt_s;
            s1_r      <= tmds_in;
            bitslip   <= slip_nxt_s;
            aligned   <= (state_nxt_s == LOCKED);
            if (state_r != LOCKED) begin
                de_out   <= 1'b0;
                data_out <= 8'h00;
                ctrl_out <= 2'b00;
            end else if (tok_hit_s) begin
                de_out   <= 1'b0;
                data_out <= 8'h00;
                ctrl_out <= tok_val_s;
            end else begin
                de_out   <= 1'b1;
                data_out <= dec_s;
                ctrl_out <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench: a driver pushes reference-model predictions per cycle and
// a monitor pops and compares them against the DUT outputs.
module tb_tmds_channel_decoder;
    localparam int LT = 8;
    localparam int SW = 1024;
    localparam int SS = 8;

    logic       pixel_clk = 1'b0;
    logic       rst       = 1'b1;
    logic [9:0] tmds_in   = 10'd0;
    logic       bitslip, aligned, de_out;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int slip_q[$];
    logic [12:0] exp_q[$];

    logic [9:0] tok_sym [4];
    initial begin
        tok_sym[0] = 10'b1101010100;
        tok_sym[1] = 10'b0010101011;
        tok_sym[2] = 10'b0101010100;
        tok_sym[3] = 10'b1010101011;
    end

    tmds_channel_decoder #(.LOCK_TOKENS(LT), .SEARCH_WINDOW(SW), .SLIP_SETTLE(SS)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .tmds_in(tmds_in), .bitslip(bitslip),
        .aligned(aligned), .de_out(de_out), .data_out(data_out), .ctrl_out(ctrl_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Reference model: mode 0=search 1=locked 2=settling after a slip
    int         m_mode = 0, m_run = 0, m_idle = 0;
    logic [9:0] m_s1   = 10'd0;
    logic       m_al = 1'b0, m_slip = 1'b0, m_de = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_ctrl = 2'b00;

    function automatic int tok_index(input logic [9:0] t);
        for (int k = 0; k < 4; k++) if (t == tok_sym[k]) return k;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] t);
        logic [7:0] q, d;
        q = t[9] ? ~t[7:0] : t[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~t[8];
        return d;
    endfunction

    task automatic model_step(input logic r, input logic [9:0] sym);
        int ti, run;
        if (r) begin
            m_mode = 0; m_run = 0; m_idle = 0; m_s1 = 10'd0;
            m_al = 0; m_slip = 0; m_de = 0; m_data = 0; m_ctrl = 0;
            return;
        end
        ti = tok_index(m_s1);
        m_de = 0; m_data = 0; m_ctrl = 0;
        if (m_mode == 1) begin
            if (ti >= 0) m_ctrl = 2'(ti);
            else begin m_de = 1; m_data = ref_decode(m_s1); end
        end
        run = (m_mode == 2 || ti < 0) ? 0 : ((m_run + 1 > LT) ? LT : m_run + 1);
        m_slip = 0;
        if (m_mode == 0) begin
            if (run == LT) begin m_mode = 1; m_idle = 0; end
            else if (m_idle == SW - 1) begin m_mode = 2; m_idle = 0; m_slip = 1; end
            else m_idle++;
        end else if (m_mode == 2) begin
            if (m_idle == SS - 1) begin m_mode = 0; m_idle = 0; end
            else m_idle++;
        end else begin
            if (ti >= 0) m_idle = 0;
            else if (m_idle == SW - 1) begin m_mode = 0; m_idle = 0; end
            else m_idle++;
        end
        m_run = run;
        m_al  = (m_mode == 1);
        m_s1  = sym;
    endtask

    task automatic drive(input logic r, input logic [9:0] sym);
        @(negedge pixel_clk);
        rst = r;
        tmds_in = sym;
        model_step(r, sym);
        exp_q.push_back({m_al, m_slip, m_de, m_data, m_ctrl});
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        s = 10'($urandom_range(0, 1023));
        while (tok_index(s) >= 0) s = 10'($urandom_range(0, 1023));
        return s;
    endfunction

    // Monitor: compare every cycle's outputs against the oldest prediction
    initial begin
        logic [12:0] e;
        forever begin
            @(posedge pixel_clk);
            if (rst) cyc = 0; else cyc++;
            #1;
            if (bitslip === 1'b1) slip_q.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({aligned, bitslip, de_out, data_out, ctrl_out} !== e) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got al=%b bs=%b de=%b d=%h c=%b expected al=%b bs=%b de=%b d=%h c=%b",
                             cyc, aligned, bitslip, de_out, data_out, ctrl_out,
                             e[12], e[11], e[10], e[9:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int kind, len, total;
        // 1: reset held while tokens arrive
        repeat (3) drive(1'b1, tok_sym[0]);
        // 2: lock on eight tokens, then data symbols
        repeat (8) drive(1'b0, tok_sym[0]);
        drive(1'b0, 10'b0100000000);
        drive(1'b0, 10'b1000000000);
        repeat (20) drive(1'b0, rand_data());
        // 3: continuous misalignment from reset release
        drive(1'b1, 10'b0100000000);
        slip_q.delete();
        repeat (2100) drive(1'b0, 10'b0100000000);
        check("slip_count", slip_q.size(), 2);
        if (slip_q.size() >= 2) begin
            check("first_slip_cycle", slip_q[0], 1024);
            check("slip_period", slip_q[1] - slip_q[0], 1032);
        end
        check("misaligned_aligned", int'(aligned), 0);
        // 4: broken token run, then a full run
        drive(1'b1, 10'd0);
        repeat (7) drive(1'b0, tok_sym[0]);
        drive(1'b0, rand_data());
        repeat (8) drive(1'b0, tok_sym[1]);
        repeat (4) drive(1'b0, rand_data());
        check("relock_after_break", int'(aligned), 1);
        // 5: lock lost after a full window of data; gap one short keeps lock
        repeat (SW) drive(1'b0, 10'b0100000000);
        drive(1'b0, 10'b0100000000);
        check("lock_dropped", int'(aligned), 0);
        repeat (8) drive(1'b0, tok_sym[0]);
        repeat (SW - 1) drive(1'b0, rand_data());
        drive(1'b0, tok_sym[3]);
        repeat (3) drive(1'b0, rand_data());
        check("gap_keeps_lock", int'(aligned), 1);
        // 6: control token while locked, then reset mid-line
        repeat (8) drive(1'b0, tok_sym[2]);
        repeat (3) drive(1'b0, 10'b0101010100);
        repeat (2) drive(1'b1, 10'b0101010100);
        repeat (4) drive(1'b0, rand_data());
        // Random token/data bursts with occasional resets
        total = 0;
        while (total < 5000) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                len = $urandom_range(1, 12);
                repeat (len) drive(1'b0, tok_sym[$urandom_range(0, 3)]);
            end else if (kind < 8) begin
                len = $urandom_range(1, 40);
                repeat (len) drive(1'b0, rand_data());
            end else if (kind == 8) begin
                len = $urandom_range(1000, 1100);
                repeat (len) drive(1'b0, rand_data());
            end else begin
                len = 1;
                drive(1'b1, rand_data());
            end
            total += len;
        end
        repeat (3) @(posedge pixel_clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
